// File: rtl/latch_id_ex.sv
// ID/EX pipeline register: debug-step gating, branch/jump flush, valid tracking, sticky halt.
// Optional bubble counter output o_bubble_count when LATCH_ID_EX_STATS_EN is defined.
module latch_id_ex #(
  parameter int NB_DATA = 32,
  parameter int NB_PC   = 32,
  parameter int NB_REG  = 5
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_step,
  input  logic               i_flush,
  input  logic [20:0]        i_ctrl,
  input  logic               i_halt,
  input  logic [NB_PC-1:0]   i_pc4,
  input  logic [NB_DATA-1:0] i_data_a,
  input  logic [NB_DATA-1:0] i_data_b,
  input  logic [NB_DATA-1:0] i_imm,
  input  logic [NB_REG-1:0]  i_rs,
  input  logic [NB_REG-1:0]  i_rt,
  input  logic [NB_REG-1:0]  i_rd,
  input  logic [4:0]         i_shamt,
  output logic [20:0]        o_ctrl,
  output logic               o_halt,
  output logic               o_valid,
  output logic [NB_PC-1:0]   o_pc4,
  output logic [NB_DATA-1:0] o_data_a,
  output logic [NB_DATA-1:0] o_data_b,
  output logic [NB_DATA-1:0] o_imm,
  output logic [NB_REG-1:0]  o_rs,
  output logic [NB_REG-1:0]  o_rt,
  output logic [NB_REG-1:0]  o_rd,
  output logic [4:0]         o_shamt
`ifdef LATCH_ID_EX_STATS_EN
  ,
  output logic [31:0]        o_bubble_count
`endif
);

  logic [20:0]        ctrl_reg;
  logic               halt_reg;
  logic               valid_reg;
  logic [NB_PC-1:0]   pc4_reg;
  logic [NB_DATA-1:0] data_a_reg;
  logic [NB_DATA-1:0] data_b_reg;
  logic [NB_DATA-1:0] imm_reg;
  logic [NB_REG-1:0]  rs_reg;
  logic [NB_REG-1:0]  rt_reg;
  logic [NB_REG-1:0]  rd_reg;
  logic [4:0]         shamt_reg;
  logic               halt_seen_reg;

  // Once HALT has entered EX, every later step inserts a bubble.
  logic squash;
  assign squash = i_flush | halt_seen_reg;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ctrl_reg      <= '0;
      halt_reg      <= 1'b0;
      valid_reg     <= 1'b0;
      pc4_reg       <= '0;
      data_a_reg    <= '0;
      data_b_reg    <= '0;
      imm_reg       <= '0;
      rs_reg        <= '0;
      rt_reg        <= '0;
      rd_reg        <= '0;
      shamt_reg     <= '0;
      halt_seen_reg <= 1'b0;
    end else if (i_step) begin
      if (squash) begin
        ctrl_reg   <= '0;
        halt_reg   <= halt_seen_reg;
        valid_reg  <= 1'b0;
        pc4_reg    <= '0;
        data_a_reg <= '0;
        data_b_reg <= '0;
        imm_reg    <= '0;
        rs_reg     <= '0;
        rt_reg     <= '0;
        rd_reg     <= '0;
        shamt_reg  <= '0;
      end else begin
        ctrl_reg   <= i_ctrl;
        halt_reg   <= i_halt;
        valid_reg  <= 1'b1;
        pc4_reg    <= i_pc4;
        data_a_reg <= i_data_a;
        data_b_reg <= i_data_b;
        imm_reg    <= i_imm;
        rs_reg     <= i_rs;
        rt_reg     <= i_rt;
        rd_reg     <= i_rd;
        shamt_reg  <= i_shamt;
        if (i_halt) begin
          halt_seen_reg <= 1'b1;
        end
      end
    end
  end

  assign o_ctrl   = ctrl_reg;
  assign o_halt   = halt_reg;
  assign o_valid  = valid_reg;
  assign o_pc4    = pc4_reg;
  assign o_data_a = data_a_reg;
  assign o_data_b = data_b_reg;
  assign o_imm    = imm_reg;
  assign o_rs     = rs_reg;
  assign o_rt     = rt_reg;
  assign o_rd     = rd_reg;
  assign o_shamt  = shamt_reg;

`ifdef LATCH_ID_EX_STATS_EN
  // A zero control word from a stall counts as a bubble even though it is captured as valid.
  logic        bubble_event;
  logic [31:0] bubble_count_reg;

  assign bubble_event = i_step & (squash | ((i_ctrl == 21'd0) & ~i_halt));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      bubble_count_reg <= '0;
    end else if (bubble_event && (bubble_count_reg != 32'hFFFF_FFFF)) begin
      bubble_count_reg <= bubble_count_reg + 32'd1;
    end
  end

  assign o_bubble_count = bubble_count_reg;
`endif

endmodule

// File: tb/tb_latch_id_ex.sv
// Self-checking bench for latch_id_ex: per-cycle model comparison plus directed literal checks.
// Stats checks are compiled in only when LATCH_ID_EX_STATS_EN is defined.
module tb_latch_id_ex;

  logic        clk = 1'b0;
  logic        rst;
  logic        step;
  logic        flush;
  logic [20:0] ctrl;
  logic        halt;
  logic [31:0] pc4, data_a, data_b, imm;
  logic [4:0]  rs, rt, rd, shamt;

  logic [20:0] o_ctrl;
  logic        o_halt, o_valid;
  logic [31:0] o_pc4, o_data_a, o_data_b, o_imm;
  logic [4:0]  o_rs, o_rt, o_rd, o_shamt;
`ifdef LATCH_ID_EX_STATS_EN
  logic [31:0] o_bubble_count;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  latch_id_ex #(.NB_DATA(32), .NB_PC(32), .NB_REG(5)) dut (
    .i_clk(clk), .i_reset(rst), .i_step(step), .i_flush(flush),
    .i_ctrl(ctrl), .i_halt(halt), .i_pc4(pc4), .i_data_a(data_a),
    .i_data_b(data_b), .i_imm(imm), .i_rs(rs), .i_rt(rt), .i_rd(rd),
    .i_shamt(shamt),
    .o_ctrl(o_ctrl), .o_halt(o_halt), .o_valid(o_valid), .o_pc4(o_pc4),
    .o_data_a(o_data_a), .o_data_b(o_data_b), .o_imm(o_imm),
    .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd), .o_shamt(o_shamt)
`ifdef LATCH_ID_EX_STATS_EN
    , .o_bubble_count(o_bubble_count)
`endif
  );

  // What EX should see: either the decoded instruction or an empty slot.
  typedef struct packed {
    logic [20:0] ctrl;
    logic        halt;
    logic        valid;
    logic [31:0] pc4, a, b, imm;
    logic [4:0]  rs, rt, rd, shamt;
  } entry_t;

  entry_t      m_ex;
  logic        m_halted = 1'b0;
  logic [31:0] m_bubbles = 32'd0;
  logic        m_ready = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_ex      <= '0;
      m_halted  <= 1'b0;
      m_bubbles <= 32'd0;
      m_ready   <= 1'b1;
    end else if (step) begin
      if (flush || m_halted) begin
        m_ex <= '{ctrl: 21'd0, halt: m_halted, valid: 1'b0, pc4: 32'd0, a: 32'd0,
                   b: 32'd0, imm: 32'd0, rs: 5'd0, rt: 5'd0, rd: 5'd0, shamt: 5'd0};
      end else begin
        m_ex <= '{ctrl: ctrl, halt: halt, valid: 1'b1, pc4: pc4, a: data_a,
                  b: data_b, imm: imm, rs: rs, rt: rt, rd: rd, shamt: shamt};
        m_halted <= m_halted | halt;
      end
      if ((flush || m_halted || (ctrl == 21'd0 && !halt)) && m_bubbles != 32'hFFFF_FFFF)
        m_bubbles <= m_bubbles + 32'd1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: outputs settle after posedge, so check on the falling edge.
  always @(negedge clk) begin
    if (m_ready) begin
      chk("model ctrl",   {11'd0, o_ctrl},  {11'd0, m_ex.ctrl});
      chk("model halt",   {31'd0, o_halt},  {31'd0, m_ex.halt});
      chk("model valid",  {31'd0, o_valid}, {31'd0, m_ex.valid});
      chk("model pc4",    o_pc4,    m_ex.pc4);
      chk("model data_a", o_data_a, m_ex.a);
      chk("model data_b", o_data_b, m_ex.b);
      chk("model imm",    o_imm,    m_ex.imm);
      chk("model rs",     {27'd0, o_rs},    {27'd0, m_ex.rs});
      chk("model rt",     {27'd0, o_rt},    {27'd0, m_ex.rt});
      chk("model rd",     {27'd0, o_rd},    {27'd0, m_ex.rd});
      chk("model shamt",  {27'd0, o_shamt}, {27'd0, m_ex.shamt});
`ifdef LATCH_ID_EX_STATS_EN
      chk("model bubble_count", o_bubble_count, m_bubbles);
`endif
    end
  end

  task automatic set_data(input int seed);
    pc4    = 32'h0040_0000 + 32'(seed) * 4;
    data_a = 32'hA500_0000 ^ 32'(seed);
    data_b = 32'h005A_0000 + 32'(seed);
    imm    = 32'hFFFF_0000 | 32'(seed);
    rs     = 5'(seed);
    rt     = 5'(seed + 1);
    rd     = 5'(seed + 2);
    shamt  = 5'(seed + 3);
  endtask

  task automatic drive(input logic s, input logic f, input logic [20:0] c, input logic h);
    step = s; flush = f; ctrl = c; halt = h;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with every input driven high.
    rst = 1'b1; drive(1'b1, 1'b1, 21'h1FFFFF, 1'b1);
    pc4 = '1; data_a = '1; data_b = '1; imm = '1; rs = '1; rt = '1; rd = '1; shamt = '1;
    tick();
    chk("reset ctrl",   {11'd0, o_ctrl}, 32'd0);
    chk("reset valid",  {31'd0, o_valid}, 32'd0);
    chk("reset halt",   {31'd0, o_halt}, 32'd0);
    chk("reset data_a", o_data_a, 32'd0);

    // Normal capture.
    rst = 1'b0; set_data(7); data_a = 32'h1234; rt = 5'd9;
    drive(1'b1, 1'b0, 21'h0_0600, 1'b0);
    tick();
    chk("capture ctrl",   {11'd0, o_ctrl}, 32'h0600);
    chk("capture data_a", o_data_a, 32'h1234);
    chk("capture rt",     {27'd0, o_rt}, 32'd9);
    chk("capture valid",  {31'd0, o_valid}, 32'd1);

    // Hold for 3 cycles while inputs churn, including flush.
    for (int i = 0; i < 3; i++) begin
      set_data(20 + i);
      drive(1'b0, 1'(i), 21'h1FFFFF, 1'(i == 2));
      tick();
    end
    chk("hold ctrl",   {11'd0, o_ctrl}, 32'h0600);
    chk("hold data_a", o_data_a, 32'h1234);
    chk("hold valid",  {31'd0, o_valid}, 32'd1);

    // Flush loads a bubble.
    set_data(30); drive(1'b1, 1'b1, 21'h1FFFFF, 1'b0);
    tick();
    chk("flush ctrl",  {11'd0, o_ctrl}, 32'd0);
    chk("flush valid", {31'd0, o_valid}, 32'd1 - 32'd1);
    chk("flush pc4",   o_pc4, 32'd0);

    // Flush while not stepping is ignored.
    set_data(40); drive(1'b1, 1'b0, 21'h1_2345, 1'b0);
    tick();
    set_data(41); drive(1'b0, 1'b1, 21'h0_0F0F, 1'b0);
    tick();
    chk("held-flush ctrl",  {11'd0, o_ctrl}, 32'h1_2345);
    chk("held-flush valid", {31'd0, o_valid}, 32'd1);
    chk("held-flush pc4",   o_pc4, 32'h0040_0000 + 40 * 4);

    // Stall word of all zeros still counts as a valid entry.
    set_data(42); drive(1'b1, 1'b0, 21'd0, 1'b0);
    tick();
    chk("zero-ctrl valid", {31'd0, o_valid}, 32'd1);
    chk("zero-ctrl ctrl",  {11'd0, o_ctrl}, 32'd0);

    // Halt capture, then sticky bubbles.
    set_data(50); drive(1'b1, 1'b0, 21'h0_0200, 1'b1);
    tick();
    chk("halt o_halt", {31'd0, o_halt}, 32'd1);
    chk("halt valid",  {31'd0, o_valid}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      set_data(51 + i); drive(1'b1, 1'b0, 21'h0_0601, 1'b0);
      tick();
      chk("post-halt o_halt", {31'd0, o_halt}, 32'd1);
      chk("post-halt ctrl",   {11'd0, o_ctrl}, 32'd0);
      chk("post-halt valid",  {31'd0, o_valid}, 32'd0);
    end
    // Reset asserted while holding still clears.
    rst = 1'b1; drive(1'b0, 1'b0, 21'h0_0601, 1'b0);
    tick();
    chk("halt reset o_halt", {31'd0, o_halt}, 32'd0);
    rst = 1'b0;

    // Flush wins over halt on the same edge.
    set_data(60); drive(1'b1, 1'b1, 21'h0_0600, 1'b1);
    tick();
    chk("flush-vs-halt o_halt", {31'd0, o_halt}, 32'd0);
    chk("flush-vs-halt valid",  {31'd0, o_valid}, 32'd0);
    set_data(61); drive(1'b1, 1'b0, 21'h0_0400, 1'b0);
    tick();
    chk("after flush-halt valid", {31'd0, o_valid}, 32'd1);
    chk("after flush-halt ctrl",  {11'd0, o_ctrl}, 32'h0400);
    chk("after flush-halt rs",    {27'd0, o_rs}, 32'd29);

`ifdef LATCH_ID_EX_STATS_EN
    rst = 1'b1; tick(); rst = 1'b0;
    set_data(70); drive(1'b1, 1'b1, 21'h0_0600, 1'b0); tick();
    set_data(71); drive(1'b1, 1'b1, 21'h0_0600, 1'b0); tick();
    set_data(72); drive(1'b1, 1'b0, 21'd0, 1'b0); tick();
    set_data(73); drive(1'b0, 1'b1, 21'd0, 1'b0); tick();
    set_data(74); drive(1'b1, 1'b0, 21'h0_0600, 1'b0); tick();
    chk("stats bubble_count", o_bubble_count, 32'd3);
`endif

    // Mixed stream exercised against the model only.
    for (int i = 0; i < 40; i++) begin
      set_data(100 + i);
      rst = ($urandom_range(0, 15) == 0);
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
            ($urandom_range(0, 4) == 0) ? 21'd0 : 21'($urandom), 1'($urandom_range(0, 9) == 0));
      tick();
    end
    rst = 1'b0; drive(1'b0, 1'b0, 21'd0, 1'b0);
    @(negedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/latch_id_ex.md
Name: latch_id_ex

Overview:
- ID/EX pipeline register of the MIPS core.
- Captures the hazard-gated control word, register operands, extended immediate, register indices and PC+4 from decode, and presents them to execute.
- Implements debug-step gating, branch/jump flush, valid tracking and sticky halt propagation.
- Sits directly downstream of the hazard control mux and upstream of the EX stage and forwarding unit.

Parameters:
NB_DATA, 32, width of register operands and immediate
NB_PC, 32, width of PC+4
NB_REG, 5, width of register indices

Ports:
i_clk  in  1  core clock
i_reset  in  1  synchronous, active-high reset
i_step  in  1  pipeline advance enable from debug unit; 0 = hold all state
i_flush  in  1  squash the instruction being captured (taken branch/jump in ID)
i_ctrl  in  21  packed control word from hazard mux (mapping below)
i_halt  in  1  halt flag from hazard mux
i_pc4  in  NB_PC  PC+4 of decode instruction
i_data_a  in  NB_DATA  rs read data
i_data_b  in  NB_DATA  rt read data
i_imm  in  NB_DATA  extended immediate
i_rs / i_rt / i_rd  in  NB_REG each  register indices
i_shamt  in  5  shift amount
o_ctrl  out  21  registered control word
o_halt  out  1  registered sticky halt
o_valid  out  1  1 = o_* holds a real instruction, 0 = bubble
o_pc4, o_data_a, o_data_b, o_imm, o_rs, o_rt, o_rd, o_shamt  out  widths as inputs  registered copies

Behaviour:
- Control mapping: [20] reg_dst_rd, [19] jump, [18] jal, [17] branch, [16] neq_branch, [15] mem_read, [14] mem_to_reg, [13:12] alu_op, [11] mem_write, [10] alu_src, [9] reg_write, [8:7] extension_mode, [6:5] datamem_size, [4:3] data_load_size, [2] zero_extend, [1] lui, [0] jalR.
- All updates on posedge i_clk; latency is 1 cycle from capture to output.
- Internal state: halt_seen (sticky).
- Per-edge priority:
  1. i_reset=1: every output and halt_seen = 0, regardless of i_step.
  2. i_step=0: hold all outputs and state, including while i_flush=1. Flush is ignored when not stepping.
  3. i_step=1 and (i_flush=1 or halt_seen=1): load a bubble.
     - o_ctrl = 0, o_valid = 0.
     - Data, index, shamt and pc4 outputs = 0.
     - o_halt = halt_seen.
  4. i_step=1 otherwise: capture all inputs.
     - o_valid = 1.
     - o_halt = i_halt.
     - If i_halt=1, set halt_seen = 1.
- Halt: once captured, o_halt stays 1 on every later step until reset. All later captures are bubbles, so nothing after HALT enters EX.
- Flush on the same edge that i_halt=1 arrives: the flush wins. Halt is not captured and halt_seen is unchanged.
- An all-zero i_ctrl from a hazard stall with i_flush=0 is captured as a normal entry: o_valid=1, o_ctrl=0.
- Reset asserted mid-hold (i_step=0) still clears everything on the next edge.

Optional Feature:
LATCH_ID_EX_STATS_EN
- Defined: adds output o_bubble_count, 32 bits.
  - Reset to 0.
  - Increments on each edge with i_reset=0, i_step=1 and (i_flush=1, or halt_seen=1, or i_ctrl==0 with i_halt=0).
  - Saturates at 32'hFFFFFFFF.
- Undefined: the port and counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset: i_reset=1 with i_step=1 and all inputs 1s → next edge: o_ctrl=0, o_valid=0, o_halt=0, o_data_a=0.
- Capture: i_step=1, i_ctrl=21'h0_0600 (reg_write, alu_src), i_data_a=32'h1234, i_rt=5'd9 → after 1 edge: o_ctrl=21'h0_0600, o_data_a=32'h1234, o_rt=9, o_valid=1. With i_step=0 for 3 cycles and changing inputs, outputs stay unchanged.
- Flush: i_step=1, i_flush=1, i_ctrl=21'h1FFFFF → o_ctrl=0, o_valid=0, o_pc4=0. Repeat with i_step=0 and i_flush=1 → outputs hold the prior values.
- Halt: capture with i_halt=1 → o_halt=1, o_valid=1. The next 4 steps with i_halt=0 and non-zero i_ctrl give o_halt=1, o_ctrl=0, o_valid=0. i_reset=1 then clears o_halt to 0.
- Flush vs halt: i_step=1, i_flush=1, i_halt=1 → o_halt=0. The next normal step with i_halt=0 captures normally with o_valid=1.
- Stats (macro defined): 2 flush steps, 1 zero-ctrl step, 1 held cycle and 1 normal step → o_bubble_count=3.
